// File: rtl/b2g_pkg.sv
// Shared types and helpers for the shared binary-to-Gray conversion path.
package b2g_pkg;

    // Widest word the generic Gray helper handles; callers zero-extend into it.
    localparam int MAX_W = 32;

    // Binary to Gray on a MAX_W-wide word; callers truncate back to their width.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Ceiling log2 with a floor of 1, so a 2-requester index still has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/b2g_rr_arbiter.sv
// Round-robin requester search: first valid requester at or after ptr wins.
module b2g_rr_arbiter
    import b2g_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    // Walk the requesters starting at ptr, wrapping at NUM_REQ-1, stop at first hit.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/b2g_share_arbiter.sv
// Shares one binary-to-Gray path between NUM_REQ requesters through a single
// registered output slot with valid/ready handshake on both sides.
module b2g_share_arbiter
    import b2g_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    localparam int IDW    = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_bin,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_gray,
    output logic [WIDTH-1:0]         out_bin,
    output logic [IDW-1:0]           out_id
);

    logic [IDW-1:0]     rr_ptr_r;
    logic [NUM_REQ-1:0] grant_s;
    logic [IDW-1:0]     idx_s;
    logic               any_s;
    logic               free_s;
    logic               xfer_s;
    logic [WIDTH-1:0]   word_s;
    logic [WIDTH-1:0]   gray_s;
    logic [IDW-1:0]     ptr_next_s;

    b2g_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .grant (grant_s),
        .idx   (idx_s),
        .any   (any_s)
    );

    // Slot can take a word when empty or being drained; nothing is accepted in reset.
    always_comb begin
        free_s    = !rst && (!out_valid || out_ready);
        xfer_s    = free_s && any_s;
        req_ready = free_s ? grant_s : {NUM_REQ{1'b0}};
        word_s    = req_bin[idx_s*WIDTH +: WIDTH];
        gray_s    = WIDTH'(bin2gray(MAX_W'(word_s)));
        if (idx_s == IDW'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = idx_s + 1'b1;
        end
    end

    // Output slot and round-robin pointer; a drain without refill keeps the data fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_gray  <= '0;
            out_bin   <= '0;
            out_id    <= '0;
            rr_ptr_r  <= '0;
        end else if (xfer_s) begin
            out_valid <= 1'b1;
            out_gray  <= gray_s;
            out_bin   <= word_s;
            out_id    <= idx_s;
            rr_ptr_r  <= ptr_next_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_b2g_share_arbiter.sv
// Directed scoreboard bench for b2g_share_arbiter (NUM_REQ=4, WIDTH=4).
module tb_b2g_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_bin;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_gray;
    logic [3:0]  out_bin;
    logic [1:0]  out_id;

    b2g_share_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_bin   (req_bin),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_bin   (out_bin),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       id;
        logic [3:0] bin;
        logic [3:0] gray;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // model state
    logic       mv;
    int         mptr;
    logic [3:0] last_bin, last_gray;
    int         last_id;
    logic       adj_en, have_prev;
    logic [3:0] prev_gray;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after negedge, check comb ready and slot, advance model.
    task automatic cycle(input logic [3:0] v, input logic [15:0] b, input logic ordy);
        logic       free_m;
        logic [3:0] exp_rdy;
        int         gi;
        exp_exp_blk: begin end
        req_valid = v;
        req_bin   = b;
        out_ready = ordy;
        #1;
        free_m  = !mv || ordy;
        exp_rdy = 4'b0000;
        gi      = -1;
        if (free_m) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (mptr + k) % 4;
                if (gi < 0 && v[j]) gi = j;
            end
            if (gi >= 0) exp_rdy[gi] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (mv) begin
            check("out_valid", 32'(out_valid), 32'd1);
            if (q.size() > 0) begin
                check("out_bin",  32'(out_bin),  32'(q[0].bin));
                check("out_gray", 32'(out_gray), 32'(q[0].gray));
                check("out_id",   32'(out_id),   32'(q[0].id));
                if (ordy) begin
                    if (adj_en && have_prev)
                        check("gray_adjacent", 32'($countones(out_gray ^ prev_gray)), 32'd1);
                    prev_gray = out_gray;
                    have_prev = 1'b1;
                    last_bin  = q[0].bin;
                    last_gray = q[0].gray;
                    last_id   = q[0].id;
                    void'(q.pop_front());
                end
            end else begin
                check("scoreboard_nonempty", 32'(q.size()), 32'd1);
            end
        end else begin
            check("out_valid", 32'(out_valid), 32'd0);
            check("hold_bin",  32'(out_bin),  32'(last_bin));
            check("hold_gray", 32'(out_gray), 32'(last_gray));
            check("hold_id",   32'(out_id),   32'(last_id));
        end
        if (gi >= 0) begin
            exp_t e;
            logic [3:0] w;
            w      = b[gi*4 +: 4];
            e.id   = gi;
            e.bin  = w;
            e.gray = {w[3], w[3] ^ w[2], w[2] ^ w[1], w[1] ^ w[0]};
            q.push_back(e);
            mptr = (gi + 1) % 4;
            mv   = 1'b1;
        end else if (ordy) begin
            mv = 1'b0;
        end
        @(negedge clk);
    endtask

    // Hold reset for two edges with every requester valid, then reset the model.
    task automatic do_reset(input logic ordy);
        rst       = 1'b1;
        req_valid = 4'hF;
        req_bin   = 16'h1234;
        out_ready = ordy;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("rst_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_bin",   32'(out_bin),   32'd0);
            check("rst_out_gray",  32'(out_gray),  32'd0);
            check("rst_out_id",    32'(out_id),    32'd0);
        end
        rst       = 1'b0;
        mv        = 1'b0;
        mptr      = 0;
        q.delete();
        last_bin  = 4'd0;
        last_gray = 4'd0;
        last_id   = 0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'h0;
        req_bin   = 16'h0;
        out_ready = 1'b0;
        adj_en    = 1'b0;
        have_prev = 1'b0;
        prev_gray = 4'd0;
        mv        = 1'b0;
        mptr      = 0;
        @(negedge clk);

        // 1. reset with all requesters valid
        do_reset(1'b1);

        // 2. single requester 2, word 1011
        cycle(4'b0100, 16'h0B00, 1'b1);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_gray",  32'(out_gray),  32'hE);
        check("t2_bin",   32'(out_bin),   32'hB);
        check("t2_id",    32'(out_id),    32'd2);
        cycle(4'b0000, 16'h0000, 1'b1);
        cycle(4'b0000, 16'h0000, 1'b1);

        // 3. all valid continuously: rotation one word per cycle
        for (int n = 0; n < 9; n++) cycle(4'hF, 16'hC5A3, 1'b1);

        // 4. backpressure for three cycles, then release
        for (int n = 0; n < 3; n++) cycle(4'hF, 16'h7E19, 1'b0);
        for (int n = 0; n < 4; n++) cycle(4'hF, 16'h7E19, 1'b1);
        cycle(4'h0, 16'h0000, 1'b1);
        cycle(4'h0, 16'h0000, 1'b1);

        // 5. exhaustive sweep from requester 0
        adj_en    = 1'b1;
        have_prev = 1'b0;
        for (int b = 0; b < 16; b++) cycle(4'b0001, 16'(b), 1'b1);
        check("t5_wrap_gray", 32'(out_gray), 32'h8);
        check("t5_wrap_bin",  32'(out_bin),  32'hF);
        cycle(4'b0000, 16'h0000, 1'b1);
        adj_en = 1'b0;

        // 6. reset while the slot is stalled with pointer away from zero
        cycle(4'b0100, 16'h0900, 1'b1);
        cycle(4'b0000, 16'h0000, 1'b0);
        cycle(4'b0000, 16'h0000, 1'b0);
        do_reset(1'b0);
        cycle(4'hF, 16'h4321, 1'b1);
        check("t6_first_id", 32'(out_id),  32'd0);
        check("t6_first_bin", 32'(out_bin), 32'h1);
        cycle(4'h0, 16'h0000, 1'b1);
        cycle(4'h0, 16'h0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
